// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: 32 radix-2 steps (done at E0+33), divide-by-zero/overflow in one cycle (done at E0+1).
// No input backpressure: start is dropped unless idle; busy is the stall request, flush aborts silently.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef logic [31:0] data_t;
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [2:0]  r_op;
    data_t       r_opnd;
    data_t       r_hi;
    data_t       r_lo;
    logic        r_neg;
    logic        r_busy;
    logic        r_done;
    data_t       r_result;

    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sa;
    logic        w_sb;
    logic        w_neg;
    logic        w_div_zero;
    logic        w_div_ovf;
    data_t       w_mag_a;
    data_t       w_mag_b;
    logic [32:0] w_add;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    data_t       w_step_hi;
    data_t       w_step_lo;
    logic [63:0] w_prod;
    data_t       w_div_raw;
    data_t       w_final;

    assign w_a_signed = op[2] ? ~op[0] : (op == 3'b001 || op == 3'b010);
    assign w_b_signed = op[2] ? ~op[0] : (op == 3'b001);
    assign w_sa       = w_a_signed & src_a[31];
    assign w_sb       = w_b_signed & src_b[31];
    assign w_mag_a    = w_sa ? 32'd0 - src_a : src_a;
    assign w_mag_b    = w_sb ? 32'd0 - src_b : src_b;
    // Remainder takes the dividend's sign; quotient and product take the xor.
    assign w_neg      = (op[2] && op[1]) ? w_sa : (w_sa ^ w_sb);
    assign w_div_zero = op[2] && (src_b == 32'd0);
    assign w_div_ovf  = op[2] && !op[0] && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

    // One iteration: shift-add for multiply ({hi,lo} shifts right), restoring subtract for divide.
    always_comb begin
        w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
        w_rem_sh  = {r_hi, r_lo[31]};
        w_diff    = w_rem_sh - {1'b0, r_opnd};
        w_step_hi = w_add[32:1];
        w_step_lo = {w_add[0], r_lo[31:1]};
        if (r_op[2]) begin
            if (!w_diff[32]) begin
                w_step_hi = w_diff[31:0];
                w_step_lo = {r_lo[30:0], 1'b1};
            end else begin
                w_step_hi = w_rem_sh[31:0];
                w_step_lo = {r_lo[30:0], 1'b0};
            end
        end
    end

    assign w_prod    = r_neg ? 64'd0 - {r_hi, r_lo} : {r_hi, r_lo};
    assign w_div_raw = r_op[1] ? r_hi : r_lo;
    assign w_final   = r_op[2] ? (r_neg ? 32'd0 - w_div_raw : w_div_raw)
                               : ((r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_done ? w_final : r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_op     <= 3'd0;
            r_opnd   <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 6'd0;
                    if (start && !flush) begin
                        r_op <= op;
                        if (w_div_zero || w_div_ovf) begin
                            // Preload so the FIN selection yields the architectural result unsigned.
                            r_hi    <= w_div_zero ? src_a : 32'd0;
                            r_lo    <= w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
                            r_neg   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_opnd  <= op[2] ? w_mag_b : w_mag_a;
                            r_lo    <= op[2] ? w_mag_a : w_mag_b;
                            r_hi    <= 32'd0;
                            r_neg   <= w_neg;
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                FIN: begin
                    r_result <= w_final;
                    r_done   <= 1'b0;
                    r_cnt    <= 6'd0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 6'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: latency, busy window, results, fast paths, flush and reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks;
    int          errors;
    logic [31:0] sb[$];
    logic [31:0] last_exp;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is 1 time unit after an edge in an idle cycle; the next edge is E0.
    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input bit push);
        if (push) sb.push_back(exp);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat is the cycle index after E0 in which done is seen (-1 on timeout).
    task automatic wait_done(input int budget, output int lat, output int nbusy,
                             output logic busy_at_done, output logic [31:0] res);
        bit found;
        found        = 1'b0;
        lat          = -1;
        nbusy        = 0;
        busy_at_done = 1'bx;
        res          = 'x;
        for (int n = 1; n <= budget && !found; n++) begin
            if (done === 1'b1) begin
                found        = 1'b1;
                lat          = n;
                res          = result;
                busy_at_done = busy;
            end else begin
                if (busy === 1'b1) nbusy++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (sb.size() == 0) return 32'hDEAD_BEEF;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_exp = 32'd0;
    endtask

    task automatic test_mul_basic();
        int lat, nb; logic bd; logic [31:0] res, exp;
        drive_op(3'b000, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_done(40, lat, nb, bd, res);
        exp = pop_exp();
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
        checks++; if (nb !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", nb); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done got %b want 0", bd); end
        checks++; if (res !== exp) begin errors++; $display("FAIL mul_result got %h want %h", res, exp); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || result !== exp) begin
            errors++; $display("FAIL mul_hold got done=%b result=%h want 0/%h", done, result, exp);
        end
        last_exp = exp;
    endtask

    task automatic run_table(input string name, input int lat_want, input int idx,
                             input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] e);
        int lat, nb; logic bd; logic [31:0] res, exp;
        drive_op(o, a, b, e, 1'b1);
        wait_done(40, lat, nb, bd, res);
        exp = pop_exp();
        checks++; if (lat !== lat_want) begin
            errors++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, idx, lat, lat_want);
        end
        checks++; if (res !== exp) begin
            errors++; $display("FAIL %s[%0d]_result got %h want %h", name, idx, res, exp);
        end
        @(posedge clk); #1;
        checks++; if (result !== exp) begin
            errors++; $display("FAIL %s[%0d]_hold got %h want %h", name, idx, result, exp);
        end
        last_exp = exp;
    endtask

    task automatic test_mul_ops();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: run_table("mul", 33, i, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
                1: run_table("mul", 33, i, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
                2: run_table("mul", 33, i, 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
                3: run_table("mul", 33, i, 3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
                default: run_table("mul", 33, i, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
            endcase
        end
    endtask

    task automatic test_div_ops();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: run_table("div", 33, i, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
                1: run_table("div", 33, i, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
                2: run_table("div", 33, i, 3'b101, 32'd100, 32'd7, 32'd14);
                3: run_table("div", 33, i, 3'b111, 32'd100, 32'd7, 32'd2);
                4: run_table("div", 33, i, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
                5: run_table("div", 33, i, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
                default: run_table("div", 33, i, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
            endcase
        end
    endtask

    task automatic test_fast_path();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: run_table("fast", 1, i, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
                1: run_table("fast", 1, i, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
                2: run_table("fast", 1, i, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
                3: run_table("fast", 1, i, 3'b100, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);
                4: run_table("fast", 1, i, 3'b111, 32'd9, 32'd0, 32'd9);
                default: run_table("fast", 1, i, 3'b110, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);
            endcase
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] exp;
        int lat, extra;
        drive_op(3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b1);
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            if (done === 1'b1) lat = n;
            else begin
                start = 1'b1; op = 3'b101; src_a = 32'd1; src_b = 32'd0;
                @(posedge clk); #1;
            end
        end
        exp = pop_exp();
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", lat); end
        checks++; if (result !== exp) begin errors++; $display("FAIL ignore_result got %h want %h", result, exp); end
        @(posedge clk); #1;
        start = 1'b0;
        extra = 0;
        for (int n = 0; n < 4; n++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(posedge clk); #1;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_queue got %0d active cycles want 0", extra); end
        checks++; if (result !== exp) begin errors++; $display("FAIL ignore_hold got %h want %h", result, exp); end
        last_exp = exp;
    endtask

    task automatic test_flush();
        int saw, lat, nb; logic bd; logic [31:0] res, exp;
        drive_op(3'b100, 32'd100, 32'd3, 32'd0, 1'b0);
        saw = 0;
        for (int n = 1; n < 10; n++) begin
            if (done === 1'b1) saw++;
            @(posedge clk); #1;
        end
        if (done === 1'b1) saw++;
        flush = 1'b1; start = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || saw !== 0) begin
            errors++; $display("FAIL flush_done got done=%b early=%0d want 0/0", done, saw);
        end
        checks++; if (result !== last_exp) begin errors++; $display("FAIL flush_result got %h want %h", result, last_exp); end
        drive_op(3'b100, 32'd100, 32'd3, 32'd33, 1'b1);
        wait_done(40, lat, nb, bd, res);
        exp = pop_exp();
        checks++; if (lat !== 33) begin errors++; $display("FAIL flush_restart_latency got %0d want 33", lat); end
        checks++; if (res !== exp) begin errors++; $display("FAIL flush_restart_result got %h want %h", res, exp); end
        @(posedge clk); #1;
        last_exp = exp;
    endtask

    task automatic test_flush_fin();
        logic [31:0] exp;
        drive_op(3'b101, 32'd8, 32'd0, 32'hFFFF_FFFF, 1'b1);
        exp = pop_exp();
        checks++; if (done !== 1'b1 || result !== exp) begin
            errors++; $display("FAIL fin_flush_done got done=%b result=%h want 1/%h", done, result, exp);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            errors++; $display("FAIL fin_flush_after got done=%b busy=%b result=%h want 0/0/%h", done, busy, result, exp);
        end
        last_exp = exp;
    endtask

    task automatic test_back_to_back();
        int lat, nb; logic bd; logic [31:0] res, exp;
        drive_op(3'b000, 32'd3, 32'd4, 32'd12, 1'b1);
        wait_done(40, lat, nb, bd, res);
        exp = pop_exp();
        checks++; if (res !== exp) begin errors++; $display("FAIL b2b_first got %h want %h", res, exp); end
        @(posedge clk); #1;
        drive_op(3'b111, 32'd50, 32'd8, 32'd2, 1'b1);
        checks++; if (busy !== 1'b1 || result !== exp) begin
            errors++; $display("FAIL b2b_accept got busy=%b result=%h want 1/%h", busy, result, exp);
        end
        wait_done(40, lat, nb, bd, res);
        exp = pop_exp();
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
        checks++; if (res !== exp) begin errors++; $display("FAIL b2b_second got %h want %h", res, exp); end
        @(posedge clk); #1;
        last_exp = exp;
    endtask

    task automatic test_reset_mid();
        int lat, nb; logic bd; logic [31:0] res, exp;
        drive_op(3'b000, 32'd9, 32'd9, 32'd0, 1'b0);
        for (int n = 1; n < 5; n++) begin
            @(posedge clk); #1;
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL rst_mid got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
        end
        #4 rst_n = 1'b1;
        drive_op(3'b000, 32'd5, 32'd5, 32'd25, 1'b1);
        wait_done(60, lat, nb, bd, res);
        exp = pop_exp();
        checks++; if (lat !== 33) begin errors++; $display("FAIL rst_restart_latency got %0d want 33", lat); end
        checks++; if (res !== exp) begin errors++; $display("FAIL rst_restart_result got %h want %h", res, exp); end
        @(posedge clk); #1;
        last_exp = exp;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; last_exp = 32'd0;
        start = 1'b0; flush = 1'b0; op = 3'b000; src_a = 32'd0; src_b = 32'd0;
        test_reset();
        test_mul_basic();
        test_mul_ops();
        test_div_ops();
        test_fast_path();
        test_start_ignored();
        test_flush();
        test_flush_fin();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; width is fixed at 32 bits (data_t).
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled on the rising edge.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 src_a  input  32  operand A (rs1 value from the src_a mux).
REQ-007 src_b  input  32  operand B (alu_src_b from the src_b mux).
REQ-008 flush  input  1  pipeline kill; aborts any in-flight operation.
REQ-009 busy  output  1  operation in progress; the stall request to the pipeline.
REQ-010 done  output  1  single-cycle pulse; result is valid in this cycle.
REQ-011 result  output  32  operation result; holds its value until the next done.

Function
REQ-012 FSM states: IDLE, CALC, FIN.
- CALC runs a 6-bit iteration counter.
REQ-013 Accept: start=1 and state IDLE and flush=0 at an edge.
- op and src_a/src_b are latched on that edge.
- Signed operands are converted to magnitudes, and the result sign is recorded.
REQ-014 In IDLE, start is accepted, and the block returns to IDLE, only on edges where flush=0.
REQ-015 Normal path: IDLE -> CALC for exactly 32 cycles (one radix-2 shift-add or restoring-subtract step per cycle) -> FIN -> IDLE.
REQ-016 With start accepted at edge E0, busy=1 in cycles E0+1..E0+32.
- done=1 and busy=0 in cycle E0+33.
REQ-017 Divide by zero (op[2]=1, src_b=0) takes the fast path: IDLE -> FIN.
- done occurs in cycle E0+1.
- DIV/DIVU result = 0xFFFFFFFF.
- REM/REMU result = src_a.
REQ-018 Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF) takes the fast path.
- DIV result = 0x80000000.
- REM result = 0.
REQ-019 Multiply results:
- MUL = low 32 bits of the product.
- MULH = high 32 bits, signed x signed.
- MULHSU = high 32 bits, signed src_a x unsigned src_b.
- MULHU = high 32 bits, unsigned x unsigned.
- All use a 64-bit internal product.
REQ-020 Division results truncate toward zero.
- The remainder sign equals the dividend sign.
- Sign correction is applied in the FIN cycle.
REQ-021 start while busy=1 or in FIN is ignored.
- It is not queued, and the in-flight operation is unaffected.
REQ-022 flush=1 at any edge forces state IDLE and clears the counter.
- No done is produced for the aborted operation.
- result is unchanged.
REQ-023 flush and start in the same cycle: flush wins and start is ignored.
REQ-024 flush in the FIN cycle: done is still asserted combinationally in that cycle.
- result updates at the edge, and the block enters IDLE.
REQ-025 result is registered and updates only at the FIN-exit edge.
- done is high in FIN, with result driven from the final datapath value.
REQ-026 A new start may be accepted in the cycle immediately after done (back-to-back).

Reset
REQ-027 rst_n=0 asynchronously forces:
- state=IDLE, counter=0, busy=0, done=0, result=0x00000000.
- All operand and partial registers cleared.
REQ-028 Reset asserted mid-CALC discards the operation; no done follows deassertion.
REQ-029 After rst_n deasserts, the first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-030 MUL 7 x 6, start at edge E0 -> busy in cycles E0+1..E0+32; done in E0+33 with result=42.
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000000.
- MULHU same operands -> result=0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 2 -> result=0xFFFFFFFF.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-033 DIVU 5 / 0 -> done in E0+1 with result=0xFFFFFFFF.
- REM 0x80000000 / 0xFFFFFFFF -> done in E0+1 with result=0.
REQ-034 DIV 100 / 3 with flush at cycle E0+10, and start asserted in that same cycle -> no done.
- busy=0 from E0+11 and result keeps its prior value.
- A start at E0+11 completes normally with done at E0+44.
REQ-035 rst_n pulsed low at E0+5 of a MUL -> all outputs 0 immediately, and done never asserts for that operation.
